// File: rtl/gru_pkg.sv
// Shared GRU frame constants, FSM state encoding and counter sizing helper.
// Pure declarations: no logic, no latency, no flow control.
package gru_pkg;

   localparam int FIXED_DEF      = 32;
   localparam int NB_INPUTS_DEF  = 24;
   localparam int NB_NEURONS_DEF = 24;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } gru_fsm_e;

   // Width of a counter that must index the larger of the two vectors.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/gru_frame_io_if.sv
// Bundles the input stream, GRU core hookup and output stream of gru_frame_io.
// slave is the block's own view; master is the view of whatever drives it.
interface gru_frame_io_if #(
   parameter int FIXED      = gru_pkg::FIXED_DEF,
   parameter int NB_INPUTS  = gru_pkg::NB_INPUTS_DEF,
   parameter int NB_NEURONS = gru_pkg::NB_NEURONS_DEF
);

   logic                          in_valid;
   logic                          in_ready;
   logic [FIXED-1:0]              in_data;
   logic                          in_last;

   logic [NB_INPUTS*FIXED-1:0]    gru_input;
   logic                          gru_start;
   logic                          gru_done;
   logic [NB_NEURONS*FIXED-1:0]   gru_state;

   logic                          out_valid;
   logic                          out_ready;
   logic [FIXED-1:0]              out_data;
   logic                          out_last;
   logic                          frame_err;

   modport slave (
      input  in_valid, in_data, in_last,
      input  gru_done, gru_state,
      input  out_ready,
      output in_ready,
      output gru_input, gru_start,
      output out_valid, out_data, out_last, frame_err
   );

   modport master (
      output in_valid, in_data, in_last,
      output gru_done, gru_state,
      output out_ready,
      input  in_ready,
      input  gru_input, gru_start,
      input  out_valid, out_data, out_last, frame_err
   );

endinterface

// File: rtl/gru_frame_io.sv
// Gathers a framed word stream into the GRU input vector, fires one start per good frame and streams back the state.
// Start one cycle after the final input word; output one cycle after gru_done; in_ready low outside LOAD, output holds while out_ready=0.
module gru_frame_io
   import gru_pkg::*;
#(
   parameter int FIXED      = FIXED_DEF,
   parameter int NB_INPUTS  = NB_INPUTS_DEF,
   parameter int NB_NEURONS = NB_NEURONS_DEF
) (
   input  logic           clk,
   input  logic           rst,
   gru_frame_io_if.slave  io
);

   localparam int            CW       = cnt_width(NB_INPUTS, NB_NEURONS);
   localparam logic [CW-1:0] IDX_LAST = CW'(NB_INPUTS - 1);
   localparam logic [CW-1:0] ODX_LAST = CW'(NB_NEURONS - 1);

   gru_fsm_e                    state;
   logic [CW-1:0]               idx;
   logic [CW-1:0]               odx;
   logic [NB_INPUTS*FIXED-1:0]  gru_input_q;
   logic [NB_NEURONS*FIXED-1:0] snapshot;
   logic                        gru_start_q;
   logic                        out_valid_q;
   logic                        out_last_q;
   logic                        frame_err_q;
   logic                        in_hs;
   logic                        out_hs;

   // Gated by rst so the block is not ready while held in reset, and ready on the first cycle after.
   assign io.in_ready  = (state == LOAD) && !rst;
   assign in_hs        = io.in_valid && io.in_ready;
   assign out_hs       = out_valid_q && io.out_ready;

   assign io.gru_input = gru_input_q;
   assign io.gru_start = gru_start_q;
   assign io.out_valid = out_valid_q;
   assign io.out_last  = out_last_q;
   assign io.frame_err = frame_err_q;
   assign io.out_data  = snapshot[odx*FIXED +: FIXED];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= LOAD;
         idx         <= '0;
         odx         <= '0;
         gru_input_q <= '0;
         snapshot    <= '0;
         gru_start_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         gru_start_q <= 1'b0;
         frame_err_q <= 1'b0;
         case (state)
            LOAD: begin
               if (in_hs) begin
                  gru_input_q[idx*FIXED +: FIXED] <= io.in_data;
                  if (idx == IDX_LAST && io.in_last) begin
                     idx         <= '0;
                     gru_start_q <= 1'b1;
                     state       <= START;
                  end else if (idx == IDX_LAST || io.in_last) begin
                     // Short or unterminated frame: drop it; its words get overwritten by the next one.
                     idx         <= '0;
                     frame_err_q <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            START: begin
               state <= WAIT;
            end
            WAIT: begin
               if (io.gru_done) begin
                  snapshot    <= io.gru_state;
                  odx         <= '0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (ODX_LAST == '0);
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  if (odx == ODX_LAST) begin
                     odx         <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     state       <= LOAD;
                  end else begin
                     odx        <= odx + 1'b1;
                     out_last_q <= ((odx + 1'b1) == ODX_LAST);
                  end
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gru_frame_io.sv
// Self-checking bench for gru_frame_io: vector table of frames plus reset/ignore corner sequences.
module tb_gru_frame_io;
   import gru_pkg::*;

   localparam int FX = FIXED_DEF;
   localparam int NI = NB_INPUTS_DEF;
   localparam int NN = NB_NEURONS_DEF;
   localparam int VW = NI * FX;
   localparam int SW = NN * FX;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gru_frame_io_if #(.FIXED(FX), .NB_INPUTS(NI), .NB_NEURONS(NN)) io ();

   gru_frame_io #(.FIXED(FX), .NB_INPUTS(NI), .NB_NEURONS(NN)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   typedef struct {
      logic [FX-1:0] data;
      logic          last;
   } out_t;

   typedef struct {
      int            nwords;
      int            last_at;
      int            gap;
      logic [FX-1:0] base;
      bit            exp_err;
      bit            exp_start;
      logic [FX-1:0] st_base;
      int            rdy_mode;
   } vec_t;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            start_cnt = 0;
   int            err_cnt   = 0;
   int            model_idx = 0;
   logic [VW-1:0] exp_vec   = '0;
   logic [VW-1:0] start_q[$];
   out_t          sb[$];
   vec_t          vecs[6];

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event did not occur within bound", name);
   endtask

   // Scoreboard side: GRU start requests and output words are checked against queued expectations.
   always @(negedge clk) begin : mon
      out_t tmp;
      if (!rst) begin
         if (io.gru_start) begin
            start_cnt++;
            if (start_q.size() == 0) fail_now("unexpected_gru_start");
            else chk("gru_input_at_start", io.gru_input, start_q.pop_front());
         end
         if (io.frame_err) err_cnt++;
         if (io.out_valid) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_out_valid");
            end else begin
               chk("out_data", io.out_data, sb[0].data);
               chk("out_last", io.out_last, sb[0].last);
               if (io.out_ready) tmp = sb.pop_front();
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [FX-1:0] d, input logic last);
      int t;
      t = 0;
      io.in_valid = 1'b1;
      io.in_data  = d;
      io.in_last  = last;
      while (!io.in_ready && t < 200) begin
         cycle();
         t++;
      end
      if (!io.in_ready) fail_now("in_ready_wait");
      // Bench's own framing model: accepted word lands at the current slot.
      exp_vec[model_idx*FX +: FX] = d;
      if (model_idx == NI - 1 && last) start_q.push_back(exp_vec);
      if (last || model_idx == NI - 1) model_idx = 0;
      else model_idx++;
      cycle();
      io.in_valid = 1'b0;
      io.in_last  = 1'b0;
   endtask

   task automatic run_frame(input vec_t v);
      int s0, e0;
      s0 = start_cnt;
      e0 = err_cnt;
      for (int w = 1; w <= v.nwords; w++) begin
         send_word(v.base + FX'(w - 1), w == v.last_at);
         if (w == v.nwords) begin
            chk("gru_start_latency", io.gru_start, v.exp_start);
            chk("frame_err_pulse", io.frame_err, v.exp_err);
         end else begin
            repeat (v.gap) cycle();
         end
      end
      repeat (3) cycle();
      chk("start_count", start_cnt - s0, v.exp_start);
      chk("err_count", err_cnt - e0, v.exp_err);
      chk("in_ready_after_frame", io.in_ready, !v.exp_start);
      chk("gru_input_held", io.gru_input, exp_vec);
   endtask

   task automatic run_gru(input logic [FX-1:0] st_base, input int rdy_mode);
      logic [SW-1:0] st;
      out_t          e;
      int            t;
      for (int i = 0; i < NN; i++) begin
         st[i*FX +: FX] = st_base + FX'(32'h100 * i);
         e.data = st[i*FX +: FX];
         e.last = (i == NN - 1);
         sb.push_back(e);
      end
      io.gru_state = st;
      io.gru_done  = 1'b1;
      cycle();
      io.gru_done  = 1'b0;
      io.gru_state = ~st;
      chk("out_valid_latency", io.out_valid, 1'b1);
      t = 0;
      while ((sb.size() != 0 || io.out_valid) && t < 1000) begin
         case (rdy_mode)
            0:       io.out_ready = 1'b1;
            1:       io.out_ready = (t % 2 == 0);
            default: io.out_ready = 1'($urandom_range(0, 1));
         endcase
         cycle();
         t++;
      end
      io.out_ready = 1'b0;
      if (t >= 1000) fail_now("drain_timeout");
      chk("drain_words_left", sb.size(), 0);
      chk("out_valid_after_drain", io.out_valid, 1'b0);
      chk("in_ready_after_drain", io.in_ready, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{nwords: 24, last_at: 24, gap: 0, base: 32'h1,        exp_err: 0, exp_start: 1, st_base: 32'h0,        rdy_mode: 0};
      vecs[1] = '{nwords: 10, last_at: 10, gap: 0, base: 32'h50,       exp_err: 1, exp_start: 0, st_base: 32'h0,        rdy_mode: 0};
      vecs[2] = '{nwords: 24, last_at: 24, gap: 0, base: 32'h1000,     exp_err: 0, exp_start: 1, st_base: 32'hA000_0000, rdy_mode: 1};
      vecs[3] = '{nwords: 24, last_at: 0,  gap: 0, base: 32'h2000,     exp_err: 1, exp_start: 0, st_base: 32'h0,        rdy_mode: 0};
      vecs[4] = '{nwords: 1,  last_at: 1,  gap: 2, base: 32'h3000,     exp_err: 1, exp_start: 0, st_base: 32'h0,        rdy_mode: 0};
      vecs[5] = '{nwords: 24, last_at: 24, gap: 1, base: 32'hDEAD_0000, exp_err: 0, exp_start: 1, st_base: 32'h5A5A_0000, rdy_mode: 2};

      io.in_valid  = 1'b0;
      io.in_data   = '0;
      io.in_last   = 1'b0;
      io.gru_done  = 1'b0;
      io.gru_state = '0;
      io.out_ready = 1'b0;

      repeat (3) cycle();
      chk("rst_in_ready", io.in_ready, 1'b0);
      chk("rst_out_valid", io.out_valid, 1'b0);
      chk("rst_out_last", io.out_last, 1'b0);
      chk("rst_gru_start", io.gru_start, 1'b0);
      chk("rst_frame_err", io.frame_err, 1'b0);
      chk("rst_gru_input", io.gru_input, '0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", io.in_ready, 1'b1);

      // gru_done while idle in LOAD must be ignored.
      io.gru_state = {NN{32'hBAD0_BAD0}};
      io.gru_done  = 1'b1;
      cycle();
      io.gru_done  = 1'b0;
      repeat (3) begin
         cycle();
         chk("load_done_ignored_valid", io.out_valid, 1'b0);
      end
      chk("load_done_ignored_ready", io.in_ready, 1'b1);

      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v]);
         if (vecs[v].exp_start) run_gru(vecs[v].st_base, vecs[v].rdy_mode);
      end

      // Reset while waiting for the GRU: frame aborted, late gru_done ignored.
      run_frame(vecs[0]);
      #2;
      rst = 1'b1;
      #1;
      chk("wait_rst_out_valid", io.out_valid, 1'b0);
      chk("wait_rst_in_ready", io.in_ready, 1'b0);
      chk("wait_rst_gru_input", io.gru_input, '0);
      exp_vec   = '0;
      model_idx = 0;
      cycle();
      rst = 1'b0;
      io.gru_state = {NN{32'h1234_5678}};
      io.gru_done  = 1'b1;
      cycle();
      io.gru_done  = 1'b0;
      repeat (4) begin
         cycle();
         chk("post_rst_done_ignored", io.out_valid, 1'b0);
      end
      chk("post_rst_in_ready", io.in_ready, 1'b1);

      // Reset part-way through LOAD: partial frame dropped, next frame starts from word 0.
      for (int w = 0; w < 5; w++) send_word(32'h7700 + FX'(w), 1'b0);
      rst = 1'b1;
      exp_vec   = '0;
      model_idx = 0;
      cycle();
      rst = 1'b0;
      #1;
      vecs[0].base = 32'h4400;
      run_frame(vecs[0]);
      run_gru(32'h0BAD_0000, 1);

      repeat (3) cycle();
      chk("start_queue_empty", start_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gru_frame_io.md
GRU_FRAME_IO -- requirements
Module: gru_frame_io

Interface
REQ-001 SHALL have parameter FIXED, default 32, width of one fixed-point word.
REQ-002 SHALL have parameter NB_INPUTS, default 24, number of input words per frame.
REQ-003 SHALL have parameter NB_NEURONS, default 24, number of state words returned per frame.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: in_valid  in  1  upstream word valid; in_ready  out  1  block accepts word; in_data  in  FIXED  input word; in_last  in  1  upstream marks final word of frame.
REQ-006 SHALL have ports: gru_input  out  NB_INPUTS*FIXED  packed input vector to GRU; gru_start  out  1  one-cycle compute request; gru_done  in  1  GRU result valid pulse; gru_state  in  NB_NEURONS*FIXED  packed GRU state vector.
REQ-007 SHALL have ports: out_valid  out  1  state word valid; out_ready  in  1  downstream accepts; out_data  out  FIXED  state word; out_last  out  1  final state word; frame_err  out  1  one-cycle framing error pulse.

Function
REQ-008 SHALL implement FSM states LOAD, START, WAIT, DRAIN.
REQ-009 LOAD: in_ready=1; each handshake (in_valid & in_ready) writes in_data to gru_input[idx*FIXED +: FIXED] and increments idx from 0.
REQ-010 Handshake with idx=NB_INPUTS-1 and in_last=1: idx->0, next state START.
REQ-011 Handshake with in_last=1 and idx<NB_INPUTS-1, or idx=NB_INPUTS-1 and in_last=0: frame_err=1 next cycle, idx->0, remain LOAD, frame discarded (no gru_start).
REQ-012 START: gru_start=1 for exactly one cycle; next state WAIT; in_ready=0.
REQ-013 WAIT: gru_input held constant; gru_done=1 captures gru_state into an internal snapshot register at that edge; next state DRAIN.
REQ-014 gru_done SHALL be ignored in LOAD, START and DRAIN.
REQ-015 DRAIN: out_valid=1, out_data=snapshot[odx*FIXED +: FIXED], odx from 0; out_last=1 iff odx=NB_NEURONS-1.
REQ-016 out_data/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 Handshake on word with out_last=1: odx->0, out_valid->0, next state LOAD.
REQ-018 Latency: final input handshake at edge k -> gru_start high cycle k+1; gru_done sampled at edge m -> out_valid high cycle m+1.
REQ-019 gru_input SHALL only change on LOAD handshakes; stale words from a discarded frame are overwritten by the next frame.
REQ-020 No arithmetic on data; words pass bit-exact, word 0 in LSBs.

Reset
REQ-021 While rst=1: state LOAD, idx=0, odx=0, gru_input=0, snapshot=0, gru_start=0, out_valid=0, out_last=0, frame_err=0, in_ready=0.
REQ-022 First cycle after rst deasserts: in_ready=1.
REQ-023 rst mid-frame (any state) SHALL abort the frame; no gru_start or out_valid issued for it.

Structure
REQ-024 Shared package gru_pkg SHALL hold FIXED, NB_INPUTS, NB_NEURONS defaults and the FSM state enum.
REQ-025 Single module, no sub-module; idx/odx counters sized $clog2 of max(NB_INPUTS, NB_NEURONS).

Verification
REQ-026 Send words 1..24, in_last on 24th -> gru_input word i = i+1, gru_start one cycle later, single pulse.
REQ-027 Drive gru_done with gru_state word i = 0x100*i, out_ready=1 -> 24 out words 0x000..0x1700, out_last on 24th, in_ready=1 next cycle.
REQ-028 in_last on 10th word -> frame_err pulse, no gru_start; then full valid frame -> normal start.
REQ-029 out_ready toggling 1/0 every cycle during DRAIN -> out_data stable while stalled, all 24 words in order.
REQ-030 rst asserted in WAIT, gru_done pulsed after release -> ignored, out_valid stays 0, in_ready=1.
REQ-031 gru_done pulsed during LOAD -> no state change, no out_valid.
